// File: rtl/pipe_ctrl_unit.sv
// pipe_ctrl_unit: pipelined control path.
// Decodes the ID-stage opcode into a control bundle and carries that bundle
// through the ID/EX, EX/MEM and MEM/WB registers. Each stage therefore sees
// the controls of the instruction it currently holds.
// Also handles the load-use stall, the EX-resolved flush, x0 write masking
// and a HALT drain FSM (RUN -> DRAIN -> HALTED).
module pipe_ctrl_unit #(
    parameter int REG_ADDR_W   = 5,
    parameter int DRAIN_STAGES = 3,
    parameter int EXT_OPS      = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  id_valid,
    input  logic [6:0]            id_opcode,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  flush,
    output logic                  stall,
    output logic                  ex_valid,
    output logic                  ex_alusrc,
    output logic [1:0]            ex_aluop,
    output logic                  ex_branch,
    output logic                  ex_jump,
    output logic                  ex_jumpreg,
    output logic [REG_ADDR_W-1:0] ex_rd,
    output logic                  mem_memread,
    output logic                  mem_memwrite,
    output logic [REG_ADDR_W-1:0] mem_rd,
    output logic                  wb_regwrite,
    output logic                  wb_memtoreg,
    output logic [REG_ADDR_W-1:0] wb_rd,
    output logic                  halted
);

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_HALT  = 7'b1111111;

    localparam logic [1:0] ST_RUN    = 2'b00;
    localparam logic [1:0] ST_DRAIN  = 2'b01;
    localparam logic [1:0] ST_HALTED = 2'b10;

    localparam int CNT_W = $clog2(DRAIN_STAGES + 1);
    localparam logic [REG_ADDR_W-1:0] RD_ZERO = {REG_ADDR_W{1'b0}};

    // Decoded controls in ID.
    logic       w_alusrc;
    logic [1:0] w_aluop;
    logic       w_branch;
    logic       w_jump;
    logic       w_jumpreg;
    logic       w_memread;
    logic       w_memwrite;
    logic       w_memtoreg;
    logic       w_dec_regwrite;
    logic       w_regwrite;
    logic       w_is_halt;
    logic       w_uses_rs1;
    logic       w_uses_rs2;

    // Hazard / steering.
    logic w_running;
    logic w_raw_stall;
    logic w_bubble;
    logic w_halt_accept;

    // ID/EX register.
    logic                  r_ex_valid;
    logic                  r_ex_alusrc;
    logic [1:0]            r_ex_aluop;
    logic                  r_ex_branch;
    logic                  r_ex_jump;
    logic                  r_ex_jumpreg;
    logic                  r_ex_memread;
    logic                  r_ex_memwrite;
    logic                  r_ex_memtoreg;
    logic                  r_ex_regwrite;
    logic [REG_ADDR_W-1:0] r_ex_rd;

    // EX/MEM register.
    logic                  r_mem_memread;
    logic                  r_mem_memwrite;
    logic                  r_mem_memtoreg;
    logic                  r_mem_regwrite;
    logic [REG_ADDR_W-1:0] r_mem_rd;

    // MEM/WB register.
    logic                  r_wb_regwrite;
    logic                  r_wb_memtoreg;
    logic [REG_ADDR_W-1:0] r_wb_rd;

    // Halt FSM.
    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_halted;

    // Opcode decode into the control bundle and the source-use flags.
    always_comb begin
        w_alusrc       = 1'b0;
        w_aluop        = 2'b00;
        w_branch       = 1'b0;
        w_jump         = 1'b0;
        w_jumpreg      = 1'b0;
        w_memread      = 1'b0;
        w_memwrite     = 1'b0;
        w_memtoreg     = 1'b0;
        w_dec_regwrite = 1'b0;
        w_is_halt      = 1'b0;
        w_uses_rs1     = 1'b0;
        w_uses_rs2     = 1'b0;
        case (id_opcode)
            OP_R: begin
                w_dec_regwrite = 1'b1;
                w_aluop        = 2'b10;
                w_uses_rs1     = 1'b1;
                w_uses_rs2     = 1'b1;
            end
            OP_I: begin
                w_dec_regwrite = 1'b1;
                w_alusrc       = 1'b1;
                w_aluop        = 2'b10;
                w_uses_rs1     = 1'b1;
            end
            OP_LW: begin
                w_alusrc       = 1'b1;
                w_memread      = 1'b1;
                w_memtoreg     = 1'b1;
                w_dec_regwrite = 1'b1;
                w_uses_rs1     = 1'b1;
            end
            OP_SW: begin
                w_alusrc   = 1'b1;
                w_memwrite = 1'b1;
                w_uses_rs1 = 1'b1;
                w_uses_rs2 = 1'b1;
            end
            OP_BR: begin
                w_branch   = 1'b1;
                w_aluop    = 2'b01;
                w_uses_rs1 = 1'b1;
                w_uses_rs2 = 1'b1;
            end
            OP_JAL: begin
                w_jump         = 1'b1;
                w_dec_regwrite = 1'b1;
            end
            OP_JALR: begin
                w_alusrc       = 1'b1;
                w_jump         = 1'b1;
                w_jumpreg      = 1'b1;
                w_dec_regwrite = 1'b1;
                w_aluop        = 2'b11;
                w_uses_rs1     = 1'b1;
            end
            OP_LUI, OP_AUIPC: begin
                // Without the extension these opcodes fall back to NOP controls.
                if (EXT_OPS != 0) begin
                    w_dec_regwrite = 1'b1;
                    w_alusrc       = 1'b1;
                end else begin
                    w_dec_regwrite = 1'b0;
                    w_alusrc       = 1'b0;
                end
            end
            OP_HALT: begin
                w_is_halt = 1'b1;
            end
            default: begin
                w_is_halt = 1'b0;
            end
        endcase
    end

    // x0 is never written: mask RegWrite at decode so later stages stay simple.
    assign w_regwrite = w_dec_regwrite & (id_rd != RD_ZERO);

    // Load-use detection, bubble selection and the combinational stall.
    assign w_running   = (r_state == ST_RUN);
    assign w_raw_stall = id_valid & r_ex_valid & r_ex_memread & (r_ex_rd != RD_ZERO) &
                         ((w_uses_rs1 & (r_ex_rd == id_rs1)) |
                          (w_uses_rs2 & (r_ex_rd == id_rs2)));
    assign w_bubble      = flush | w_raw_stall | ~id_valid | ~w_running;
    assign w_halt_accept = w_running & ~w_bubble & w_is_halt;
    assign stall         = (w_raw_stall & ~flush) | ~w_running;

    // ID/EX register: load the decoded bundle or insert a bubble.
    always_ff @(posedge clk) begin
        if (reset || w_bubble) begin
            r_ex_valid    <= 1'b0;
            r_ex_alusrc   <= 1'b0;
            r_ex_aluop    <= 2'b00;
            r_ex_branch   <= 1'b0;
            r_ex_jump     <= 1'b0;
            r_ex_jumpreg  <= 1'b0;
            r_ex_memread  <= 1'b0;
            r_ex_memwrite <= 1'b0;
            r_ex_memtoreg <= 1'b0;
            r_ex_regwrite <= 1'b0;
            r_ex_rd       <= RD_ZERO;
        end else begin
            r_ex_valid    <= 1'b1;
            r_ex_alusrc   <= w_alusrc;
            r_ex_aluop    <= w_aluop;
            r_ex_branch   <= w_branch;
            r_ex_jump     <= w_jump;
            r_ex_jumpreg  <= w_jumpreg;
            r_ex_memread  <= w_memread;
            r_ex_memwrite <= w_memwrite;
            r_ex_memtoreg <= w_memtoreg;
            r_ex_regwrite <= w_regwrite;
            r_ex_rd       <= id_rd;
        end
    end

    // EX/MEM and MEM/WB registers: advance every edge; they never stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mem_memread  <= 1'b0;
            r_mem_memwrite <= 1'b0;
            r_mem_memtoreg <= 1'b0;
            r_mem_regwrite <= 1'b0;
            r_mem_rd       <= RD_ZERO;
            r_wb_regwrite  <= 1'b0;
            r_wb_memtoreg  <= 1'b0;
            r_wb_rd        <= RD_ZERO;
        end else begin
            r_mem_memread  <= r_ex_memread;
            r_mem_memwrite <= r_ex_memwrite;
            r_mem_memtoreg <= r_ex_memtoreg;
            r_mem_regwrite <= r_ex_regwrite;
            r_mem_rd       <= r_ex_rd;
            r_wb_regwrite  <= r_mem_regwrite;
            r_wb_memtoreg  <= r_mem_memtoreg;
            r_wb_rd        <= r_mem_rd;
        end
    end

    // Halt FSM: the first accepted HALT starts a fixed drain, then halts sticky.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_RUN;
            r_cnt    <= {CNT_W{1'b0}};
            r_halted <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_halt_accept) begin
                        r_state <= ST_DRAIN;
                        r_cnt   <= CNT_W'(DRAIN_STAGES);
                    end else begin
                        r_state <= ST_RUN;
                    end
                end
                ST_DRAIN: begin
                    if (r_cnt == CNT_W'(1)) begin
                        r_state  <= ST_HALTED;
                        r_halted <= 1'b1;
                    end else begin
                        r_state <= ST_DRAIN;
                    end
                    r_cnt <= r_cnt - CNT_W'(1);
                end
                ST_HALTED: begin
                    r_state  <= ST_HALTED;
                    r_halted <= 1'b1;
                end
                default: begin
                    r_state <= ST_HALTED;
                    r_halted <= 1'b1;
                end
            endcase
        end
    end

    assign ex_valid     = r_ex_valid;
    assign ex_alusrc    = r_ex_alusrc;
    assign ex_aluop     = r_ex_aluop;
    assign ex_branch    = r_ex_branch;
    assign ex_jump      = r_ex_jump;
    assign ex_jumpreg   = r_ex_jumpreg;
    assign ex_rd        = r_ex_rd;
    assign mem_memread  = r_mem_memread;
    assign mem_memwrite = r_mem_memwrite;
    assign mem_rd       = r_mem_rd;
    assign wb_regwrite  = r_wb_regwrite;
    assign wb_memtoreg  = r_wb_memtoreg;
    assign wb_rd        = r_wb_rd;
    assign halted       = r_halted;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Randomized bench for pipe_ctrl_unit. Two instances (EXT_OPS=1 and 0) share
// stimulus; a per-instruction reference model tracks what each stage holds.
module tb_pipe_ctrl_unit;

    localparam int DRAIN = 3;

    typedef struct packed {
        logic       v;
        logic       alusrc;
        logic [1:0] aluop;
        logic       br;
        logic       j;
        logic       jr;
        logic       mr;
        logic       mw;
        logic       m2r;
        logic       rw;
        logic [4:0] rd;
    } ctl_t;

    logic       clk = 1'b0;
    logic       reset, id_valid, flush;
    logic [6:0] id_opcode;
    logic [4:0] id_rs1, id_rs2, id_rd;

    logic       stall_1, ex_valid_1, ex_alusrc_1, ex_branch_1, ex_jump_1, ex_jumpreg_1;
    logic [1:0] ex_aluop_1;
    logic [4:0] ex_rd_1, mem_rd_1, wb_rd_1;
    logic       mem_memread_1, mem_memwrite_1, wb_regwrite_1, wb_memtoreg_1, halted_1;

    logic       stall_0, ex_valid_0, ex_alusrc_0, ex_branch_0, ex_jump_0, ex_jumpreg_0;
    logic [1:0] ex_aluop_0;
    logic [4:0] ex_rd_0, mem_rd_0, wb_rd_0;
    logic       mem_memread_0, mem_memwrite_0, wb_regwrite_0, wb_memtoreg_0, halted_0;

    int n_checks = 0;
    int n_pass   = 0;

    // Model state: stage contents per instance [ext][0=EX,1=MEM,2=WB].
    ctl_t st[2][3];
    ctl_t nxt[2];
    int   cyc;
    int   halt_at;

    always #5 clk = ~clk;

    pipe_ctrl_unit #(.REG_ADDR_W(5), .DRAIN_STAGES(DRAIN), .EXT_OPS(1)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .flush(flush),
        .stall(stall_1), .ex_valid(ex_valid_1), .ex_alusrc(ex_alusrc_1),
        .ex_aluop(ex_aluop_1), .ex_branch(ex_branch_1), .ex_jump(ex_jump_1),
        .ex_jumpreg(ex_jumpreg_1), .ex_rd(ex_rd_1), .mem_memread(mem_memread_1),
        .mem_memwrite(mem_memwrite_1), .mem_rd(mem_rd_1), .wb_regwrite(wb_regwrite_1),
        .wb_memtoreg(wb_memtoreg_1), .wb_rd(wb_rd_1), .halted(halted_1)
    );

    pipe_ctrl_unit #(.REG_ADDR_W(5), .DRAIN_STAGES(DRAIN), .EXT_OPS(0)) dut0 (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .flush(flush),
        .stall(stall_0), .ex_valid(ex_valid_0), .ex_alusrc(ex_alusrc_0),
        .ex_aluop(ex_aluop_0), .ex_branch(ex_branch_0), .ex_jump(ex_jump_0),
        .ex_jumpreg(ex_jumpreg_0), .ex_rd(ex_rd_0), .mem_memread(mem_memread_0),
        .mem_memwrite(mem_memwrite_0), .mem_rd(mem_rd_0), .wb_regwrite(wb_regwrite_0),
        .wb_memtoreg(wb_memtoreg_0), .wb_rd(wb_rd_0), .halted(halted_0)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Control bundle an instruction carries, straight from the opcode table.
    function automatic ctl_t decode(input logic [6:0] op, input logic [4:0] rd, input bit ext);
        ctl_t c = '0;
        c.v  = 1'b1;
        c.rd = rd;
        case (op)
            7'b0110011: begin c.rw = 1'b1; c.aluop = 2'b10; end
            7'b0010011: begin c.rw = 1'b1; c.alusrc = 1'b1; c.aluop = 2'b10; end
            7'b0000011: begin c.alusrc = 1'b1; c.mr = 1'b1; c.m2r = 1'b1; c.rw = 1'b1; end
            7'b0100011: begin c.alusrc = 1'b1; c.mw = 1'b1; end
            7'b1100011: begin c.br = 1'b1; c.aluop = 2'b01; end
            7'b1101111: begin c.j = 1'b1; c.rw = 1'b1; end
            7'b1100111: begin c.alusrc = 1'b1; c.j = 1'b1; c.jr = 1'b1; c.rw = 1'b1; c.aluop = 2'b11; end
            7'b0110111, 7'b0010111: if (ext) begin c.rw = 1'b1; c.alusrc = 1'b1; end
            default: c.rw = 1'b0;
        endcase
        if (rd == 5'd0) c.rw = 1'b0;
        return c;
    endfunction

    function automatic bit reads_rs1(input logic [6:0] op);
        return op inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b1100111};
    endfunction

    function automatic bit reads_rs2(input logic [6:0] op);
        return op inside {7'b0110011, 7'b0100011, 7'b1100011};
    endfunction

    function automatic bit model_running();
        return halt_at < 0;
    endfunction

    function automatic bit model_halted();
        return (halt_at >= 0) && (cyc >= halt_at + DRAIN);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) for (int s = 0; s < 3; s++) st[k][s] = '0;
        cyc     = 0;
        halt_at = -1;
    endtask

    function automatic bit load_use();
        return id_valid && st[1][0].v && st[1][0].mr && (st[1][0].rd != 5'd0) &&
               ((reads_rs1(id_opcode) && st[1][0].rd == id_rs1) ||
                (reads_rs2(id_opcode) && st[1][0].rd == id_rs2));
    endfunction

    // Compare the registered outputs of both instances against the model.
    task automatic check_outputs();
        for (int k = 0; k < 2; k++) begin
            logic [31:0] g_ex, g_mem, g_wb, g_h;
            ctl_t e, m, w;
            e = st[k][0]; m = st[k][1]; w = st[k][2];
            if (k == 1) begin
                g_ex  = {20'd0, ex_valid_1, ex_alusrc_1, ex_aluop_1, ex_branch_1, ex_jump_1, ex_jumpreg_1, ex_rd_1};
                g_mem = {25'd0, mem_memread_1, mem_memwrite_1, mem_rd_1};
                g_wb  = {25'd0, wb_regwrite_1, wb_memtoreg_1, wb_rd_1};
                g_h   = {31'd0, halted_1};
            end else begin
                g_ex  = {20'd0, ex_valid_0, ex_alusrc_0, ex_aluop_0, ex_branch_0, ex_jump_0, ex_jumpreg_0, ex_rd_0};
                g_mem = {25'd0, mem_memread_0, mem_memwrite_0, mem_rd_0};
                g_wb  = {25'd0, wb_regwrite_0, wb_memtoreg_0, wb_rd_0};
                g_h   = {31'd0, halted_0};
            end
            check_val($sformatf("ex_bundle ext%0d cyc%0d", k, cyc), g_ex,
                      {20'd0, e.v, e.alusrc, e.aluop, e.br, e.j, e.jr, e.rd});
            check_val($sformatf("mem_bundle ext%0d cyc%0d", k, cyc), g_mem,
                      {25'd0, m.mr, m.mw, m.rd});
            check_val($sformatf("wb_bundle ext%0d cyc%0d", k, cyc), g_wb,
                      {25'd0, w.rw, w.m2r, w.rd});
            check_val($sformatf("halted ext%0d cyc%0d", k, cyc), g_h,
                      {31'd0, model_halted()});
        end
    endtask

    logic [6:0] op_tab [0:9];

    initial begin
        op_tab[0] = 7'b0110011; op_tab[1] = 7'b0010011; op_tab[2] = 7'b0000011;
        op_tab[3] = 7'b0100011; op_tab[4] = 7'b1100011; op_tab[5] = 7'b1101111;
        op_tab[6] = 7'b1100111; op_tab[7] = 7'b0110111; op_tab[8] = 7'b0010111;
        op_tab[9] = 7'b0000011;

        reset = 1'b1; id_valid = 1'b0; flush = 1'b0;
        id_opcode = 7'd0; id_rs1 = 5'd0; id_rs2 = 5'd0; id_rd = 5'd0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        check_outputs();
        check_val("stall_after_reset", {31'd0, stall_1}, 32'd0);

        for (int i = 0; i < 4000; i++) begin
            bit raw, run, bub, exp_stall;
            int pick;
            // Random stimulus, biased toward small register indices for hazards.
            reset    = ($urandom_range(0, 79) == 0) || (model_halted() && $urandom_range(0, 5) == 0);
            id_valid = ($urandom_range(0, 7) != 0);
            flush    = ($urandom_range(0, 7) == 0);
            pick     = $urandom_range(0, 12);
            if (pick < 10)       id_opcode = op_tab[pick];
            else if (pick == 10) id_opcode = 7'($urandom);
            else if ($urandom_range(0, 4) == 0) id_opcode = 7'b1111111;
            else                 id_opcode = 7'b0000011;
            id_rs1 = 5'($urandom_range(0, 6));
            id_rs2 = 5'($urandom_range(0, 6));
            id_rd  = ($urandom_range(0, 15) == 0) ? 5'($urandom) : 5'($urandom_range(0, 6));
            #1;

            raw       = load_use();
            run       = model_running();
            exp_stall = !run || (raw && !flush);
            check_val($sformatf("stall ext1 cyc%0d", cyc), {31'd0, stall_1}, {31'd0, exp_stall});
            check_val($sformatf("stall ext0 cyc%0d", cyc), {31'd0, stall_0}, {31'd0, exp_stall});

            bub = flush || raw || !id_valid || !run;
            for (int k = 0; k < 2; k++) nxt[k] = bub ? ctl_t'('0) : decode(id_opcode, id_rd, k[0]);

            @(posedge clk);
            if (reset) begin
                model_reset();
            end else begin
                for (int k = 0; k < 2; k++) begin
                    st[k][2] = st[k][1];
                    st[k][1] = st[k][0];
                    st[k][0] = nxt[k];
                end
                cyc++;
                if (run && !bub && id_opcode == 7'b1111111) halt_at = cyc;
            end
            @(negedge clk);
            check_outputs();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
